// File: rtl/uart_tx_param.sv
// UART transmitter with a transmit FIFO and per-frame runtime configuration
// (5-8 data bits, none/even/odd/mark/space parity, 1 or 2 stop bits, runtime divisor).
module uart_tx_param #(
    parameter int CLK_FREQ     = 100000000,
    parameter int DEFAULT_BAUD = 9600,
    parameter int DIV_W        = 20,
    parameter int FIFO_DEPTH   = 16,
    parameter int CNT_W        = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_data_bits,
    input  logic [2:0]       cfg_parity,
    input  logic             cfg_stop2,
    output logic             tx,
    output logic             tx_busy,
    output logic [CNT_W-1:0] fifo_count,
    output logic             fifo_full
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(CLK_FREQ / DEFAULT_BAUD);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           r_state;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_wptr, r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [DIV_W-1:0] r_div, r_cnt;
    logic [7:0]       r_sh;
    logic [2:0]       r_bit;
    logic [1:0]       r_nb;
    logic [2:0]       r_par;
    logic             r_stop2, r_second, r_acc, r_tx, r_busy;

    logic             w_full, w_push, w_pop, w_bit_end, w_last_stop, w_par_bit;
    logic [DIV_W-1:0] w_div;
    logic [2:0]       w_par_cfg;

    assign w_full      = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_push      = s_valid && !w_full;
    assign w_bit_end   = (r_cnt == r_div - 1'b1);
    assign w_last_stop = w_bit_end && (!r_stop2 || r_second);
    assign w_pop       = (r_count != '0) &&
                         ((r_state == IDLE) || (r_state == STOP && w_last_stop));

    assign w_div = (cfg_div == '0)          ? DEF_DIV :
                   (cfg_div == DIV_W'(1))   ? DIV_W'(2) : cfg_div;
    // Unknown parity codes collapse to "none" at latch time.
    assign w_par_cfg = (cfg_parity > 3'd4) ? 3'd0 : cfg_parity;

    always_comb begin
        w_par_bit = 1'b0;
        case (r_par)
            3'd1:    w_par_bit = r_acc;
            3'd2:    w_par_bit = ~r_acc;
            3'd3:    w_par_bit = 1'b1;
            default: w_par_bit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_sh     <= '0;
            r_bit    <= '0;
            r_nb     <= '0;
            r_par    <= '0;
            r_stop2  <= 1'b0;
            r_second <= 1'b0;
            r_acc    <= 1'b0;
        end else if (w_pop) begin
            // Frame launch: shared by IDLE and the end of the last stop bit.
            r_state  <= START;
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
            r_sh     <= r_mem[r_rptr];
            r_nb     <= cfg_data_bits;
            r_par    <= w_par_cfg;
            r_stop2  <= cfg_stop2;
            r_div    <= w_div;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_acc    <= 1'b0;
            r_second <= 1'b0;
        end else begin
            if (r_state != IDLE)
                r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
            case (r_state)
                IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                end
                START: if (w_bit_end) begin
                    r_state <= DATA;
                    r_tx    <= r_sh[0];
                    r_acc   <= r_sh[0];
                    r_sh    <= r_sh >> 1;
                    r_bit   <= '0;
                end
                DATA: if (w_bit_end) begin
                    if (r_bit == 3'(r_nb) + 3'd4) begin
                        r_state <= (r_par != '0) ? PARITY : STOP;
                        r_tx    <= (r_par != '0) ? w_par_bit : 1'b1;
                    end else begin
                        r_bit <= r_bit + 1'b1;
                        r_tx  <= r_sh[0];
                        r_acc <= r_acc ^ r_sh[0];
                        r_sh  <= r_sh >> 1;
                    end
                end
                PARITY: if (w_bit_end) begin
                    r_state <= STOP;
                    r_tx    <= 1'b1;
                end
                STOP: if (w_bit_end) begin
                    if (r_stop2 && !r_second) begin
                        r_second <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_tx    <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_ready    = !w_full;
    assign fifo_full  = w_full;
    assign fifo_count = r_count;
    assign tx         = r_tx;
    assign tx_busy    = r_busy;
endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: queued expected frames are checked clock-by-clock on tx.
module tb_uart_tx_param;
    localparam int DIV_W = 20;
    localparam int CNT_W = 5;
    localparam int TMO   = 30000;

    typedef struct {
        logic [7:0] d;
        logic [1:0] nb;
        logic [2:0] par;
        logic       s2;
        int         div;
    } exp_t;

    logic             clk, rst, s_valid, s_ready, cfg_stop2, tx, tx_busy, fifo_full;
    logic [7:0]       s_data;
    logic [DIV_W-1:0] cfg_div;
    logic [1:0]       cfg_data_bits;
    logic [2:0]       cfg_parity;
    logic [CNT_W-1:0] fifo_count;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t sb[$];
    int   gaps[$];
    bit   mon_busy = 0;

    uart_tx_param dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cfg_div(cfg_div), .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity),
        .cfg_stop2(cfg_stop2), .tx(tx), .tx_busy(tx_busy),
        .fifo_count(fifo_count), .fifo_full(fifo_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff_div(input logic [DIV_W-1:0] d);
        if (d == 0) return 100000000 / 9600;
        if (d == 1) return 2;
        return int'(d);
    endfunction

    function automatic logic par_bit(input exp_t e);
        logic [7:0] m;
        logic       x;
        m = 8'hFF >> (2'd3 - e.nb);
        x = ^(e.d & m);
        case (e.par)
            3'd1:    return x;
            3'd2:    return ~x;
            3'd3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Monitor: one expected frame per start bit, every clock of every bit compared.
    initial begin
        exp_t       e;
        logic [11:0] bits;
        int         nbits, gap;
        logic       obs, busy_bad;
        forever begin
            @(negedge clk);
            if (sb.size() == 0) continue;
            mon_busy = 1;
            gap = 0;
            while (tx !== 1'b0 && gap < TMO) begin
                @(negedge clk);
                gap++;
            end
            e = sb.pop_front();
            if (gap >= TMO) begin
                chk("start_timeout", 1, 0);
                mon_busy = 0;
                continue;
            end
            gaps.push_back(gap);
            bits  = '0;
            nbits = 1;
            for (int i = 0; i < 5 + int'(e.nb); i++) begin
                bits[nbits] = e.d[i];
                nbits++;
            end
            if (e.par >= 3'd1 && e.par <= 3'd4) begin
                bits[nbits] = par_bit(e);
                nbits++;
            end
            bits[nbits] = 1'b1;
            nbits++;
            if (e.s2) begin
                bits[nbits] = 1'b1;
                nbits++;
            end
            busy_bad = 0;
            for (int b = 0; b < nbits; b++) begin
                obs = bits[b];
                for (int c = 0; c < e.div; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (tx !== bits[b]) obs = tx;
                    if (tx_busy !== 1'b1) busy_bad = 1;
                end
                chk($sformatf("bit%0d_d%02h", b, e.d), obs, bits[b]);
            end
            chk("busy_in_frame", busy_bad, 0);
            if (sb.size() == 0) begin
                @(negedge clk);
                if (sb.size() == 0) begin
                    chk("idle_busy", tx_busy, 0);
                    chk("idle_tx", tx, 1);
                end
            end
            mon_busy = 0;
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit track);
        exp_t e;
        int   n;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        n = 0;
        while (!s_ready && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) chk("ready_timeout", 1, 0);
        if (track) begin
            e.d = b; e.nb = cfg_data_bits; e.par = cfg_parity; e.s2 = cfg_stop2;
            e.div = eff_div(cfg_div);
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic release_valid();
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || mon_busy) && n < TMO) begin
            @(negedge clk);
            n++;
        end
        if (n >= TMO) chk("drain_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic set_cfg(input int d, input logic [1:0] nb, input logic [2:0] p, input logic s2);
        cfg_div = DIV_W'(d); cfg_data_bits = nb; cfg_parity = p; cfg_stop2 = s2;
    endtask

    initial begin
        int n;
        rst = 1'b1; s_valid = 1'b0; s_data = '0;
        set_cfg(10, 2'd3, 3'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_ready", s_ready, 1);
        chk("rst_count", fifo_count, 0);
        chk("rst_full", fifo_full, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1 div 10, first-word latency
        push_byte(8'h55, 1);
        @(negedge clk);
        s_valid = 1'b0;
        chk("lat_count_k", fifo_count, 1);
        chk("lat_tx_k", tx, 1);
        @(negedge clk);
        chk("lat_tx_k1", tx, 0);
        chk("lat_busy_k1", tx_busy, 1);
        chk("lat_count_k1", fifo_count, 0);
        drain();

        // 7E1 with bit 7 set: must never reach the line
        set_cfg(4, 2'd2, 3'd1, 1'b0);
        push_byte(8'hC1, 1); release_valid(); drain();
        set_cfg(3, 2'd3, 3'd2, 1'b1);
        push_byte(8'h03, 1); release_valid(); drain();
        set_cfg(3, 2'd3, 3'd3, 1'b0);
        push_byte(8'h00, 1); release_valid(); drain();
        set_cfg(3, 2'd3, 3'd4, 1'b0);
        push_byte(8'hFF, 1); release_valid(); drain();
        set_cfg(2, 2'd0, 3'd1, 1'b1);
        push_byte(8'hFD, 1); release_valid(); drain();
        set_cfg(2, 2'd1, 3'd6, 1'b0);
        push_byte(8'h2B, 1); release_valid(); drain();

        // Back-to-back frames, div 1 treated as 2
        set_cfg(1, 2'd3, 3'd0, 1'b0);
        gaps.delete();
        push_byte(8'h81, 1); push_byte(8'h7E, 1); push_byte(8'hC3, 1);
        release_valid();
        chk("b2b_count", fifo_count, 2);
        drain();
        chk("b2b_gaps", gaps.size(), 3);
        if (gaps.size() == 3) begin
            chk("b2b_gap1", gaps[1], 0);
            chk("b2b_gap2", gaps[2], 0);
        end

        // Fill the FIFO while the first frame is in flight
        set_cfg(50, 2'd3, 3'd0, 1'b0);
        for (int i = 0; i < 17; i++) push_byte(8'hA0 + 8'(i), 1);
        @(negedge clk);
        chk("full_count", fifo_count, 16);
        chk("full_flag", fifo_full, 1);
        chk("full_ready", s_ready, 0);
        s_valid = 1'b0;
        n = 0;
        while (fifo_count == 16 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("full_pop_count", fifo_count, 15);
        chk("full_pop_ready", s_ready, 1);
        drain();

        // Reset in the middle of the data bits
        set_cfg(10, 2'd3, 3'd0, 1'b0);
        push_byte(8'h00, 0); push_byte(8'h11, 0); push_byte(8'h22, 0);
        release_valid();
        repeat (30) @(negedge clk);
        chk("pre_rst_busy", tx_busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_tx", tx, 1);
        chk("mid_rst_busy", tx_busy, 0);
        chk("mid_rst_count", fifo_count, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_tx", tx, 1);
        chk("post_rst_busy", tx_busy, 0);

        // Divisor change mid-frame only affects the next frame
        push_byte(8'h5A, 1); release_valid();
        repeat (5) @(negedge clk);
        cfg_div = DIV_W'(20);
        push_byte(8'hA5, 1); release_valid();
        drain();

        // Default divisor: start bit length only, then abort
        set_cfg(0, 2'd3, 3'd0, 1'b0);
        push_byte(8'hFF, 0); release_valid();
        n = 0;
        while (tx !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (tx === 1'b0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("default_div", n, 10416);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
